// File: rtl/seg_pkg.sv
// Shared digit/segment types and helpers for the display datapath.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned BCD_W      = 4;

    localparam logic [NUM_DIGITS-1:0] SEL_OFF = 6'b111111;
    localparam logic [NUM_DIGITS-1:0] SEL_MSB = 6'b100000;

    // Element [NUM_DIGITS-1] is the leftmost (most significant) digit.
    typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] bcd_word_t;
    typedef logic [2:0]                       slot_t;

    // Active-low one-cold enable: slot 0 lights the leftmost digit.
    function automatic logic [NUM_DIGITS-1:0] slot_sel(input slot_t slot);
        return SEL_OFF ^ (SEL_MSB >> slot);
    endfunction

endpackage

// File: rtl/digit_scan_mux_if.sv
// Digit bus between the value source, the scan mux and the segment decoder.
interface digit_scan_mux_if;
    import seg_pkg::*;

    bcd_word_t             digits_in;
    logic                  load;
    logic                  blank_lz;
    logic [BCD_W-1:0]      digit_out;
    logic [NUM_DIGITS-1:0] sel;
    logic                  frame_start;

    modport master (
        output digits_in, load, blank_lz,
        input  digit_out, sel, frame_start
    );

    modport slave (
        input  digits_in, load, blank_lz,
        output digit_out, sel, frame_start
    );
endinterface

// File: rtl/scan_prescaler.sv
// Divides clk into digit slots; slot_tick marks the last cycle of a slot.
module scan_prescaler #(
    parameter  int unsigned SCAN_DIV = 50000,
    localparam int unsigned CNT_W    = $clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             slot_tick,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned LAST = SCAN_DIV - 1;

    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(LAST)) cnt_nxt = '0;
    end

    // slot_tick is registered so that it is high exactly while cnt == LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            slot_tick <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            slot_tick <= (cnt_nxt == CNT_W'(LAST));
        end
    end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexes a six-digit BCD value onto one digit bus with frame-coherent
// updates, leading-zero blanking and a dead time at the start of each slot.
module digit_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEAD_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    digit_scan_mux_if.slave    bus
);

    localparam int unsigned CNT_W     = $clog2(SCAN_DIV);
    localparam slot_t       LAST_SLOT = slot_t'(NUM_DIGITS - 1);

    bcd_word_t             pending;
    bcd_word_t             active;
    slot_t                 slot;
    logic                  slot_tick;
    logic [CNT_W-1:0]      cnt;

    logic                  wrap_c;
    logic                  run_c;
    logic [NUM_DIGITS-1:0] blank_c;
    logic [BCD_W-1:0]      cur_c;

    scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .slot_tick (slot_tick),
        .cnt       (cnt)
    );

    // A digit is blanked while it and every digit to its left are zero; the last never is.
    always_comb begin
        blank_c = '0;
        run_c   = bus.blank_lz;
        for (int k = 0; k < NUM_DIGITS - 1; k++) begin
            run_c      = run_c && (active[NUM_DIGITS-1-k] == BCD_W'(0));
            blank_c[k] = run_c;
        end
    end

    always_comb begin
        wrap_c = slot_tick && (slot == LAST_SLOT);
        cur_c  = active[LAST_SLOT - slot];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending         <= '0;
            active          <= '0;
            slot            <= '0;
            bus.digit_out   <= '0;
            bus.sel         <= SEL_OFF;
            bus.frame_start <= 1'b0;
        end else begin
            if (bus.load) pending <= bus.digits_in;
            // A load on the wrap cycle bypasses pending so the new frame shows it.
            if (wrap_c) active <= bus.load ? bus.digits_in : pending;
            if (slot_tick) slot <= (slot == LAST_SLOT) ? slot_t'(0) : slot + slot_t'(1);

            bus.digit_out   <= cur_c;
            bus.sel         <= ((cnt >= CNT_W'(DEAD_CYC)) && !blank_c[slot]) ? slot_sel(slot) : SEL_OFF;
            bus.frame_start <= (slot == slot_t'(0)) && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Randomized and directed bench for digit_scan_mux against a cycle-count reference model.
module tb_digit_scan_mux;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEAD_CYC = 1;
    localparam int unsigned FRAME    = 6 * SCAN_DIV;

    logic clk = 1'b0;
    logic rst;

    digit_scan_mux_if ifc ();

    digit_scan_mux #(.SCAN_DIV(SCAN_DIV), .DEAD_CYC(DEAD_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          m;            // clock edges since reset release
    logic [23:0] mdl_pending;
    logic [23:0] mdl_active;
    logic        cur_blz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t edge=%0d: got %0h expected %0h", tag, $time, m, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"},   32'(ifc.sel),         32'h3f);
        chk({tag, "_digit"}, 32'(ifc.digit_out),   32'h0);
        chk({tag, "_fs"},    32'(ifc.frame_start), 32'h0);
    endtask

    // Expected outputs after the next edge, derived from elapsed cycles and the shown value.
    task automatic expected(input logic bz, output logic [3:0] e_dig,
                            output logic [5:0] e_sel, output logic e_fs);
        int          k;
        int          c;
        logic [23:0] lead;
        logic        blank;
        k     = (m / SCAN_DIV) % 6;
        c     = m % SCAN_DIV;
        e_dig = 4'((mdl_active >> (4 * (5 - k))) & 24'hf);
        lead  = mdl_active >> (4 * (5 - k));
        blank = bz && (k < 5) && (lead == 24'h0);
        e_sel = 6'h3f;
        if (c >= int'(DEAD_CYC) && !blank) e_sel[5-k] = 1'b0;
        e_fs  = (m % FRAME) == 0;
    endtask

    // One clock: drive inputs, predict, clock, update model, compare. Starts and ends at negedge.
    task automatic step(input logic ld, input logic [23:0] d, input logic bz);
        logic [3:0] e_dig;
        logic [5:0] e_sel;
        logic       e_fs;
        ifc.load      = ld;
        ifc.digits_in = d;
        ifc.blank_lz  = bz;
        expected(bz, e_dig, e_sel, e_fs);
        @(posedge clk);
        if (ld) mdl_pending = d;
        m++;
        if (m % FRAME == 0) mdl_active = mdl_pending;
        #1;
        chk("digit_out",   32'(ifc.digit_out),   32'(e_dig));
        chk("sel",         32'(ifc.sel),         32'(e_sel));
        chk("frame_start", 32'(ifc.frame_start), 32'(e_fs));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'h0, cur_blz);
    endtask

    function automatic logic [23:0] rand_digits();
        logic [23:0] v;
        for (int i = 0; i < 6; i++) begin
            v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    task automatic release_reset();
        @(negedge clk);
        rst         = 1'b0;
        m           = 0;
        mdl_pending = 24'h0;
        mdl_active  = 24'h0;
    endtask

    initial begin
        rst           = 1'b1;
        ifc.load      = 1'b0;
        ifc.digits_in = 24'h0;
        ifc.blank_lz  = 1'b0;
        cur_blz       = 1'b0;
        m             = 0;
        mdl_pending   = 24'h0;
        mdl_active    = 24'h0;

        // Outputs stay at reset values while rst is held, even with load asserted.
        for (int i = 0; i < 3; i++) begin
            ifc.load      = 1'b1;
            ifc.digits_in = 24'hfedcba;
            @(posedge clk);
            #1;
            chk_reset_vals("in_reset");
        end
        ifc.load = 1'b0;
        release_reset();

        // Idle scanning of zeros.
        idle(30);

        // Load mid-frame; current frame must keep showing the old value.
        step(1'b1, 24'h123456, cur_blz);
        idle(2 * FRAME);

        // Leading-zero blanking with an embedded zero.
        cur_blz = 1'b1;
        step(1'b1, 24'h000705, cur_blz);
        idle(2 * FRAME);

        // All zeros: only the last digit lights.
        step(1'b1, 24'h000000, cur_blz);
        idle(2 * FRAME);

        // Load exactly on the wrap cycle.
        cur_blz = 1'b0;
        while ((m % FRAME) != FRAME - 1) step(1'b0, 24'h0, cur_blz);
        step(1'b1, 24'h987654, cur_blz);
        idle(FRAME + 2);

        // Non-BCD nibbles pass through and count as non-zero for blanking.
        cur_blz = 1'b1;
        step(1'b1, 24'h00a0f0, cur_blz);
        idle(2 * FRAME);

        // Random loads, values and blanking toggles.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 31) == 0) cur_blz = ~cur_blz;
            if ($urandom_range(0, 11) == 0) step(1'b1, rand_digits(), cur_blz);
            else                            step(1'b0, 24'(($urandom())), cur_blz);
        end

        // Asynchronous reset in the middle of slot 3.
        while (((m / SCAN_DIV) % 6) != 3 || (m % SCAN_DIV) != 2) step(1'b0, 24'h0, cur_blz);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(posedge clk);
        #1;
        chk_reset_vals("rst_held");
        release_reset();
        cur_blz = 1'b0;
        idle(FRAME + 6);

        // A few more random frames after the restart.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 31) == 0) cur_blz = ~cur_blz;
            step(($urandom_range(0, 9) == 0), rand_digits(), cur_blz);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
